dcim_job_seq: RTL and testbench
===============================

// Module: dcim_job_seq
// PURPOSE
//  Upstream command sequencer for the DCIM macro top. Accepts weight-load and compute commands over
//  valid/ready, drives the macro's write port (WA one-hot, D, cima) and compute controls (inwidth,
//  wwidth, acm_en, xin0, start). Waits for st, then returns nout as a result beat (with timeout flag).
// PARAMETERS
//  ROWS     8    weight rows per bank; WA width, words per load command
//  DW       24   weight word width (D)
//  XW       192  activation vector width (xin0)
//  NW       51   macro result width (nout)
//  TIMEOUT  255  max cycles in WAIT before aborting with res_err
// PORTS
//  clk          in   1    clock
//  rstn         in   1    async active-low reset
//  cmd_valid    in   1    command offered
//  cmd_ready    out  1    command accepted when valid&ready
//  cmd_load     in   1    1 = weight load of ROWS words, 0 = compute
//  cmd_bank     in   1    bank select (drives cima)
//  cmd_inwidth  in   1    0 = 12-bit input, 1 = 24-bit input
//  cmd_wwidth   in   1    0 = 12-bit weight, 1 = 24-bit weight
//  cmd_xin      in   XW   activation vector for compute
//  w_valid      in   1    weight word offered
//  w_ready      out  1    weight word accepted when valid&ready
//  w_data       in   DW   weight word, row order 0..ROWS-1
//  D            out  DW   macro write data
//  WA           out  ROWS macro one-hot write row select
//  cima         out  1    macro bank select
//  acm_en       out  1    macro accumulate enable
//  inwidth      out  1    macro input width
//  wwidth       out  1    macro weight width
//  start        out  1    macro start pulse
//  xin0         out  XW   macro activation vector
//  nout         in   NW   macro result
//  st           in   1    macro done
//  res_valid    out  1    result beat valid
//  res_ready    in   1    result beat consumed when valid&ready
//  res_data     out  NW   captured nout
//  res_err      out  1    1 = job aborted by timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except cmd_ready=1. In-flight jobs are dropped; WA/start/acm_en
//    fall to 0 immediately (asynchronous).
//  - All macro-side outputs are registered. cmd_ready=1 only in IDLE; fields are latched on accept.
//  - IDLE: load cmd -> WLOAD (row=0, cima=cmd_bank). Compute cmd -> SETUP.
//  - WLOAD: w_ready=1. On w_valid&w_ready: next cycle WA=1<<row, D=w_data, row++. Without w_valid:
//    WA=0 (no write) and row holds; bubbles are allowed. After row ROWS-1 is accepted -> GAP.
//  - GAP: one cycle with WA=0, D=0 (write to last row is one cycle wide) -> IDLE.
//  - SETUP: cima, inwidth, wwidth, xin0 driven from the latched cmd; acm_en=1. Hold one cycle -> START.
//  - START: start=1 for exactly one cycle -> WAIT. Clear timeout count; st_d <= st.
//  - WAIT: done = st & ~st_d (rising edge, registered st_d). st high on START entry does not count;
//    a fresh rising edge is required. On done: res_data<=nout, res_err=0 -> RESP. If the count reaches
//    TIMEOUT first: res_data=0, res_err=1 -> RESP. If done and timeout coincide, done wins.
//  - RESP: res_valid=1; res_data/res_err stable until res_ready. Then acm_en=0 -> IDLE. Config outputs
//    (cima, inwidth, wwidth, xin0) hold their last values while IDLE.
//  - Minimum compute latency: accept -> start = 2 cycles; st edge -> res_valid = 1 cycle.
//  - Command back-to-back: next cmd is accepted the cycle after GAP or after the RESP handshake.
// STRUCTURE
//  - dcim_pkg: state enum (IDLE, WLOAD, GAP, SETUP, START, WAIT, RESP), ROWS/DW/XW/NW defaults,
//    cnt width = $clog2(TIMEOUT+1).
//  - Sub-module dcim_st_watchdog: st edge detector + timeout counter; outputs done, timeout.
//  - Top: FSM, command latch, row counter, registered macro drive.
// TESTING
//  - Load bank0 words 1..8 with w_valid held -> WA 01,02,...,80 on 8 consecutive cycles,
//    D = 1..8, cima=0, then 1 cycle WA=0.
//  - Load bank1 with w_valid low on 2nd and 5th cycles -> WA holds 0 during bubbles; 8 writes in order.
//  - Compute (in=0,w=0,bank0,xin all-F); model st 6 cycles after start with nout=0x123 ->
//    start 1 cycle wide; res_valid with res_data=0x123, res_err=0.
//  - Compute with st held high from before start -> no completion until st falls and rises again.
//  - Compute with st never asserted -> res_valid after TIMEOUT cycles in WAIT, res_err=1, res_data=0.
//  - Reset asserted in WLOAD at row 3 -> WA=0 and cmd_ready=1 after release; a new load starts at row 0.

Source files
------------

// File: rtl/dcim_pkg.sv
// rtl/dcim_pkg.sv - shared types and defaults for the DCIM job sequencer
// Purpose : FSM state encoding, default geometry of the DCIM macro, and the
//           width helper for the completion watchdog counter.
// Ports   : none (package)
package dcim_pkg;

  localparam int ROWS_DEF    = 8;
  localparam int DW_DEF      = 24;
  localparam int XW_DEF      = 192;
  localparam int NW_DEF      = 51;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    GAP,
    SETUP,
    START,
    WAIT,
    RESP
  } state_t;

  // Counter must be able to hold TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dcim_st_watchdog.sv
// rtl/dcim_st_watchdog.sv - macro done edge detector and completion timeout
// Purpose : detects a fresh rising edge of st while waiting, and flags when the
//           wait has lasted TIMEOUT cycles.
// Ports   : clk, rstn (async active-low)
//           clr      in  clear the cycle count (sequencer in START)
//           run      in  sequencer is waiting for the macro
//           st       in  macro done level
//           done     out rising edge of st seen while running
//           timeout  out wait budget exhausted
module dcim_st_watchdog
  import dcim_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic run,
  input  logic st,
  output logic done,
  output logic timeout
);

  localparam int CW = cnt_width(TIMEOUT);

  logic          st_d;
  logic [CW-1:0] cnt;

  // st_d tracks st every cycle, so an st already high during START is
  // already in st_d on the first WAIT cycle and cannot count as done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_d <= 1'b0;
      cnt  <= '0;
    end else begin
      st_d <= st;
      if (clr)
        cnt <= '0;
      else if (run)
        cnt <= cnt + 1'b1;
    end
  end

  assign done    = run & st & ~st_d;
  // cnt counts completed WAIT cycles; the last allowed cycle is TIMEOUT-1.
  assign timeout = run & (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dcim_job_seq.sv
// rtl/dcim_job_seq.sv - command sequencer driving the DCIM macro top
// Purpose : accepts weight-load / compute commands, drives the macro write port
//           and compute controls from registers, waits for st and returns the
//           macro result (or a timeout error) as a result beat.
// Ports   : clk, rstn (async active-low)
//           cmd_*    command channel (valid/ready) with load/bank/width/xin fields
//           w_*      weight word channel (valid/ready), rows in order 0..ROWS-1
//           D, WA, cima, acm_en, inwidth, wwidth, start, xin0 : macro drive
//           nout, st : macro result and done
//           res_*    result beat channel (valid/ready) with data and error flag
module dcim_job_seq
  import dcim_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int DW      = DW_DEF,
  parameter int XW      = XW_DEF,
  parameter int NW      = NW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_load,
  input  logic            cmd_bank,
  input  logic            cmd_inwidth,
  input  logic            cmd_wwidth,
  input  logic [XW-1:0]   cmd_xin,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [DW-1:0]   w_data,
  output logic [DW-1:0]   D,
  output logic [ROWS-1:0] WA,
  output logic            cima,
  output logic            acm_en,
  output logic            inwidth,
  output logic            wwidth,
  output logic            start,
  output logic [XW-1:0]   xin0,
  input  logic [NW-1:0]   nout,
  input  logic            st,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [NW-1:0]   res_data,
  output logic            res_err
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic          done, timeout;

  dcim_st_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (state == START),
    .run     (state == WAIT),
    .st      (st),
    .done    (done),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_load ? WLOAD : SETUP;
      WLOAD:   if (w_valid && row == LAST_ROW) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      SETUP:   state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (done || timeout) state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    w_ready   = (state == WLOAD);
    res_valid = (state == RESP);
  end

  // Registered macro drive. Each output is computed one state ahead so that
  // it is valid during the state that owns it (e.g. start during START).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      D        <= '0;
      WA       <= '0;
      cima     <= 1'b0;
      acm_en   <= 1'b0;
      inwidth  <= 1'b0;
      wwidth   <= 1'b0;
      start    <= 1'b0;
      xin0     <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      row      <= '0;
    end else begin
      WA    <= '0;
      start <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cima <= cmd_bank;
          row  <= '0;
          if (!cmd_load) begin
            inwidth <= cmd_inwidth;
            wwidth  <= cmd_wwidth;
            xin0    <= cmd_xin;
            acm_en  <= 1'b1;
          end
        end
        WLOAD: if (w_valid) begin
          WA  <= {{(ROWS-1){1'b0}}, 1'b1} << row;
          D   <= w_data;
          row <= row + 1'b1;
        end
        GAP:   D <= '0;
        SETUP: start <= 1'b1;
        // done has priority when it coincides with the timeout.
        WAIT: if (done) begin
          res_data <= nout;
          res_err  <= 1'b0;
        end else if (timeout) begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
        RESP:  if (res_ready) acm_en <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcim_job_seq.sv
// tb/tb_dcim_job_seq.sv - directed self-checking bench for dcim_job_seq
module tb_dcim_job_seq;

  localparam int ROWS = 8;
  localparam int DW   = 24;
  localparam int XW   = 192;
  localparam int NW   = 51;
  localparam int TO   = 255;

  logic            clk;
  logic            rstn;
  logic            cmd_valid, cmd_ready, cmd_load, cmd_bank, cmd_inwidth, cmd_wwidth;
  logic [XW-1:0]   cmd_xin;
  logic            w_valid, w_ready;
  logic [DW-1:0]   w_data;
  logic [DW-1:0]   D;
  logic [ROWS-1:0] WA;
  logic            cima, acm_en, inwidth, wwidth, start;
  logic [XW-1:0]   xin0;
  logic [NW-1:0]   nout;
  logic            st;
  logic            res_valid, res_ready, res_err;
  logic [NW-1:0]   res_data;

  int total = 0;
  int bad   = 0;

  dcim_job_seq #(.ROWS(ROWS), .DW(DW), .XW(XW), .NW(NW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_bank(cmd_bank), .cmd_inwidth(cmd_inwidth), .cmd_wwidth(cmd_wwidth),
    .cmd_xin(cmd_xin),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .D(D), .WA(WA), .cima(cima), .acm_en(acm_en), .inwidth(inwidth),
    .wwidth(wwidth), .start(start), .xin0(xin0),
    .nout(nout), .st(st),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic ld, input logic bk, input logic iw, input logic ww,
                          input logic [XW-1:0] x);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_load    = ld;
    cmd_bank    = bk;
    cmd_inwidth = iw;
    cmd_wwidth  = ww;
    cmd_xin     = x;
    step;
    cmd_valid   = 1'b0;
  endtask

  initial begin
    logic [ROWS-1:0] exp_wa;
    int              r;
    int              n;

    rstn = 1'b0; cmd_valid = 0; cmd_load = 0; cmd_bank = 0; cmd_inwidth = 0;
    cmd_wwidth = 0; cmd_xin = '0; w_valid = 0; w_data = '0; nout = '0; st = 0;
    res_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wa", WA, 0);
    chk("rst_start", start, 0);
    chk("rst_acm_en", acm_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_w_ready", w_ready, 0);
    rstn = 1'b1;
    step;

    // bank0 load, w_valid held
    send_cmd(1, 0, 0, 0, '0);
    chk("l0_w_ready", w_ready, 1);
    chk("l0_cima", cima, 0);
    for (int i = 0; i < ROWS; i++) begin
      w_valid = 1'b1;
      w_data  = DW'(i + 1);
      step;
      exp_wa = 8'h01 << i;
      chk("l0_wa", WA, exp_wa);
      chk("l0_d", D, i + 1);
    end
    w_valid = 1'b0;
    step;
    chk("l0_gap_wa", WA, 0);
    chk("l0_gap_d", D, 0);
    chk("l0_idle", cmd_ready, 1);

    // bank1 load with bubbles on the 2nd and 5th cycles
    send_cmd(1, 1, 0, 0, '0);
    chk("l1_cima", cima, 1);
    r = 0;
    for (int c = 0; c < ROWS + 2; c++) begin
      w_valid = (c != 1) && (c != 4);
      w_data  = DW'(24'h100 + r);
      step;
      if (c == 1 || c == 4) begin
        chk("l1_bubble_wa", WA, 0);
      end else begin
        exp_wa = 8'h01 << r;
        chk("l1_wa", WA, exp_wa);
        chk("l1_d", D, 24'h100 + r);
        r++;
      end
    end
    w_valid = 1'b0;
    step;
    chk("l1_gap_wa", WA, 0);
    chk("l1_idle", cmd_ready, 1);

    // compute, st rises well after start
    send_cmd(0, 0, 0, 0, {XW{1'b1}});
    chk("c0_setup_start", start, 0);
    chk("c0_acm_en", acm_en, 1);
    chk("c0_xin0", xin0, {XW{1'b1}});
    chk("c0_cima", cima, 0);
    chk("c0_inwidth", inwidth, 0);
    step;
    chk("c0_start", start, 1);
    step;
    chk("c0_start_pulse", start, 0);
    repeat (4) step;
    chk("c0_no_res_yet", res_valid, 0);
    st = 1'b1; nout = 51'h123;
    step;
    chk("c0_res_valid", res_valid, 1);
    chk("c0_res_data", res_data, 51'h123);
    chk("c0_res_err", res_err, 0);
    nout = 51'h999;
    step;
    chk("c0_res_hold", res_valid, 1);
    chk("c0_res_data_hold", res_data, 51'h123);
    res_ready = 1'b1;
    step;
    res_ready = 1'b0;
    chk("c0_acm_off", acm_en, 0);
    chk("c0_idle", cmd_ready, 1);
    chk("c0_xin_hold", xin0, {XW{1'b1}});

    // compute with st already high before start
    st = 1'b1;
    send_cmd(0, 1, 1, 1, {96'h0, {24{4'hA}}});
    chk("c1_inwidth", inwidth, 1);
    chk("c1_wwidth", wwidth, 1);
    chk("c1_cima", cima, 1);
    step;
    chk("c1_start", start, 1);
    repeat (4) step;
    chk("c1_st_high_no_done", res_valid, 0);
    st = 1'b0;
    step;
    chk("c1_st_low", res_valid, 0);
    st = 1'b1; nout = 51'h456;
    step;
    chk("c1_res_valid", res_valid, 1);
    chk("c1_res_data", res_data, 51'h456);
    res_ready = 1'b1;
    step;
    res_ready = 1'b0;
    st = 1'b0;
    chk("c1_idle", cmd_ready, 1);

    // compute with st never asserted: timeout
    nout = 51'h777;
    send_cmd(0, 0, 0, 1, {XW{1'b0}});
    step;
    chk("c2_start", start, 1);
    n = 0;
    do begin
      step;
      n++;
    end while (!res_valid && n < 400);
    chk("c2_timeout_latency", n, TO + 1);
    chk("c2_res_err", res_err, 1);
    chk("c2_res_data", res_data, 0);
    res_ready = 1'b1;
    step;
    res_ready = 1'b0;
    chk("c2_idle", cmd_ready, 1);

    // reset while loading, at row 3
    send_cmd(1, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1;
      w_data  = DW'(i + 24'h50);
      step;
    end
    chk("rw_wa_row2", WA, 8'h04);
    #2 rstn = 1'b0;
    #1;
    chk("rw_async_wa", WA, 0);
    chk("rw_async_cima", cima, 0);
    w_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    step;
    chk("rw_cmd_ready", cmd_ready, 1);
    chk("rw_wa", WA, 0);
    send_cmd(1, 0, 0, 0, '0);
    for (int i = 0; i < ROWS; i++) begin
      w_valid = 1'b1;
      w_data  = DW'(24'hAA + i);
      step;
      if (i == 0) begin
        chk("rw_restart_wa", WA, 8'h01);
        chk("rw_restart_d", D, 24'hAA);
      end
    end
    w_valid = 1'b0;
    step;
    chk("rw_done_idle", cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
